// File: rtl/simmem_wdata_aligner.sv
// Write-address/write-data aligner in front of the delay calculator core.
// Latency: an accepted address reaches the core 1 cycle later; a late beat is forwarded in its acceptance cycle.
// Backpressure: waddr stalls while the address queue is full; wdata stalls while MaxEarlyBeats beats are held.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   waddr_valid_i/_ready_o            requester address handshake (iid, burst_len)
//   wdata_valid_i/_ready_o            requester data beat handshake
//   core_waddr_valid_o/_ready_i       queue head to core (iid, burst_len, imm_cnt)
//   core_wdata_valid_o                one pulse per beat that arrives after its address
//   early_beats_o, owed_beats_o       occupancy of the signed beat counter
module simmem_wdata_aligner #(
  parameter int AddrQueueDepth = 4,
  parameter int IidWidth       = 4,
  parameter int MaxBurstLen    = 8,
  parameter int MaxEarlyBeats  = 32,
  localparam int LenW   = $clog2(MaxBurstLen + 1),
  localparam int MaxCnt = (MaxEarlyBeats > AddrQueueDepth * MaxBurstLen) ?
                          MaxEarlyBeats : AddrQueueDepth * MaxBurstLen,
  localparam int CntW   = $clog2(MaxCnt + 1) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                waddr_valid_i,
  output logic                waddr_ready_o,
  input  logic [IidWidth-1:0] waddr_iid_i,
  input  logic [LenW-1:0]     waddr_burst_len_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  output logic                core_waddr_valid_o,
  input  logic                core_waddr_ready_i,
  output logic [IidWidth-1:0] core_waddr_iid_o,
  output logic [LenW-1:0]     core_waddr_burst_len_o,
  output logic [LenW-1:0]     core_wdata_imm_cnt_o,
  output logic                core_wdata_valid_o,
  output logic [CntW-2:0]     early_beats_o,
  output logic [CntW-2:0]     owed_beats_o
);

  localparam int PtrW = $clog2(AddrQueueDepth);
  localparam logic signed [CntW-1:0] CntZero  = '0;
  localparam logic signed [CntW-1:0] CntOne   = CntW'(1);
  localparam logic signed [CntW-1:0] MaxEarly = CntW'(MaxEarlyBeats);
  localparam logic [PtrW:0]          OccFull  = (PtrW + 1)'(AddrQueueDepth);

  // Address queue storage; contents need no reset, validity comes from occ_q.
  logic [IidWidth-1:0] iid_mem_q [AddrQueueDepth];
  logic [LenW-1:0]     len_mem_q [AddrQueueDepth];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   occ_q, occ_d;

  // Signed beat counter: positive = beats waiting for an address,
  // negative = beats still owed to addresses already handed to the core.
  logic signed [CntW-1:0] cnt_q, cnt_d, cnt_beat, head_len_s, cnt_neg;
  logic                   wdata_rdy_q, wdata_rdy_d;

  logic fifo_empty, fifo_full, push, pop, beat_acc;
  logic [LenW-1:0] imm;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OccFull);
  assign push       = waddr_valid_i && !fifo_full;
  assign pop        = !fifo_empty && core_waddr_ready_i;
  assign beat_acc   = wdata_valid_i && wdata_rdy_q;

  always_comb begin
    head_len_s = signed'(CntW'(len_mem_q[rd_ptr_q]));
    // The beat accepted this cycle is counted before the pop so it can
    // contribute to the immediate count of the address leaving now.
    cnt_beat   = beat_acc ? cnt_q + CntOne : cnt_q;
    imm        = '0;
    if (!fifo_empty && (cnt_beat > CntZero)) begin
      imm = (cnt_beat > head_len_s) ? len_mem_q[rd_ptr_q] : cnt_beat[LenW-1:0];
    end
    cnt_d       = pop ? cnt_beat - head_len_s : cnt_beat;
    wdata_rdy_d = (cnt_d < MaxEarly);
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PtrW + 1)'(1);
      2'b01:   occ_d = occ_q - (PtrW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      iid_mem_q[wr_ptr_q] <= waddr_iid_i;
      len_mem_q[wr_ptr_q] <= waddr_burst_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      wdata_rdy_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      wdata_rdy_q <= wdata_rdy_d;
    end
  end

  assign cnt_neg = CntZero - cnt_q;

  assign waddr_ready_o          = !fifo_full;
  assign wdata_ready_o          = wdata_rdy_q;
  assign core_waddr_valid_o     = !fifo_empty;
  assign core_waddr_iid_o       = iid_mem_q[rd_ptr_q];
  assign core_waddr_burst_len_o = len_mem_q[rd_ptr_q];
  assign core_wdata_imm_cnt_o   = imm;
  assign core_wdata_valid_o     = beat_acc && (cnt_q < CntZero);
  assign early_beats_o          = (cnt_q > CntZero) ? cnt_q[CntW-2:0] : '0;
  assign owed_beats_o           = (cnt_q < CntZero) ? cnt_neg[CntW-2:0] : '0;

endmodule

// File: tb/tb_simmem_wdata_aligner.sv
// Bench for simmem_wdata_aligner: one vector per clock cycle.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_simmem_wdata_aligner;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       waddr_valid_i, waddr_ready_o;
  logic [3:0] waddr_iid_i, waddr_burst_len_i;
  logic       wdata_valid_i, wdata_ready_o;
  logic       core_waddr_valid_o, core_waddr_ready_i;
  logic [3:0] core_waddr_iid_o, core_waddr_burst_len_o, core_wdata_imm_cnt_o;
  logic       core_wdata_valid_o;
  logic [5:0] early_beats_o, owed_beats_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  simmem_wdata_aligner dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .waddr_valid_i         (waddr_valid_i),
    .waddr_ready_o         (waddr_ready_o),
    .waddr_iid_i           (waddr_iid_i),
    .waddr_burst_len_i     (waddr_burst_len_i),
    .wdata_valid_i         (wdata_valid_i),
    .wdata_ready_o         (wdata_ready_o),
    .core_waddr_valid_o    (core_waddr_valid_o),
    .core_waddr_ready_i    (core_waddr_ready_i),
    .core_waddr_iid_o      (core_waddr_iid_o),
    .core_waddr_burst_len_o(core_waddr_burst_len_o),
    .core_wdata_imm_cnt_o  (core_wdata_imm_cnt_o),
    .core_wdata_valid_o    (core_wdata_valid_o),
    .early_beats_o         (early_beats_o),
    .owed_beats_o          (owed_beats_o)
  );

  // Offered burst lengths must stay within 1..MaxBurstLen.
  always @(posedge clk_i) begin
    if (!rst_i && waddr_valid_i)
      assert (waddr_burst_len_i >= 4'd1 && waddr_burst_len_i <= 4'd8);
  end

  typedef struct {
    logic       rst, wav;
    logic [3:0] iid, len;
    logic       wdv, crdy;
    logic       e_wardy, e_wdrdy, e_cv;
    logic [3:0] e_iid, e_len, e_imm;
    logic       e_pulse;
    logic [5:0] e_early, e_owed;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic wav, input int iid, input int len,
                              input logic wdv, input logic crdy,
                              input logic wardy, input logic wdrdy, input logic cv,
                              input int eiid, input int elen, input int imm, input logic pulse,
                              input int early, input int owed);
    vec_t v;
    v.rst = rst; v.wav = wav; v.iid = 4'(iid); v.len = 4'(len); v.wdv = wdv; v.crdy = crdy;
    v.e_wardy = wardy; v.e_wdrdy = wdrdy; v.e_cv = cv;
    v.e_iid = 4'(eiid); v.e_len = 4'(elen); v.e_imm = 4'(imm); v.e_pulse = pulse;
    v.e_early = 6'(early); v.e_owed = 6'(owed);
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst_i              = v.rst;
    waddr_valid_i      = v.wav;
    waddr_iid_i        = v.iid;
    waddr_burst_len_i  = v.len;
    wdata_valid_i      = v.wdv;
    core_waddr_ready_i = v.crdy;
    @(negedge clk_i);
    chk(tag, "waddr_ready", int'(waddr_ready_o), int'(v.e_wardy));
    chk(tag, "wdata_ready", int'(wdata_ready_o), int'(v.e_wdrdy));
    chk(tag, "core_valid", int'(core_waddr_valid_o), int'(v.e_cv));
    if (v.e_cv) begin
      chk(tag, "core_iid", int'(core_waddr_iid_o), int'(v.e_iid));
      chk(tag, "core_len", int'(core_waddr_burst_len_o), int'(v.e_len));
    end
    chk(tag, "imm_cnt", int'(core_wdata_imm_cnt_o), int'(v.e_imm));
    chk(tag, "wdata_pulse", int'(core_wdata_valid_o), int'(v.e_pulse));
    chk(tag, "early", int'(early_beats_o), int'(v.e_early));
    chk(tag, "owed", int'(owed_beats_o), int'(v.e_owed));
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    //                 rst wav iid len wdv crdy | wardy wdrdy cv iid len imm pulse early owed
    // Reset state, then 4 early beats and their address: imm=4, no pulses.
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 3, 4, 0, 1,  1, 1, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 3, 4, 4, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    // Address first, then 4 late beats: owed 4,3,2,1,0 with one pulse each.
    tbl.push_back(mk(0, 1, 5, 4, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 5, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    // cnt=2, a beat in the same cycle as the len=4 pop: imm=3, then owe 1.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 4, 1, 0,  1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 1, 7, 4, 3, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0));

    rst_i = 1'b1; waddr_valid_i = 1'b0; waddr_iid_i = '0; waddr_burst_len_i = 4'd1;
    wdata_valid_i = 1'b0; core_waddr_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Early-beat budget: 32 beats fill it, the 33rd is refused, a len=8 pop reopens it.
    for (int k = 0; k < 32; k++)
      apply(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, k, 0), $sformatf("fill%0d", k));
    apply(mk(0, 0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 32, 0), "full_stall");
    apply(mk(0, 1, 2, 8, 1, 0,  1, 0, 0, 0, 0, 0, 0, 32, 0), "full_addr");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 0, 1, 2, 8, 8, 0, 32, 0), "full_pop");
    apply(mk(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 24, 0), "reopen");
    apply(mk(1, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 24, 0), "rst_a");

    // Queue full: 5 addresses offered with core stalled, then drained in order.
    apply(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0), "q0");
    apply(mk(0, 1, 2, 1, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0, 0), "q1");
    apply(mk(0, 1, 3, 1, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0, 0), "q2");
    apply(mk(0, 1, 4, 1, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0, 0), "q3");
    apply(mk(0, 1, 5, 1, 0, 0,  0, 1, 1, 1, 1, 0, 0, 0, 0), "q4_full");
    apply(mk(0, 1, 5, 1, 0, 1,  0, 1, 1, 1, 1, 0, 0, 0, 0), "q5_pop_full");
    apply(mk(0, 1, 5, 1, 0, 1,  1, 1, 1, 2, 1, 0, 0, 0, 1), "q6_push_pop");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 3, 1, 0, 0, 0, 2), "q7");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 4, 1, 0, 0, 0, 3), "q8");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 5, 1, 0, 0, 0, 4), "q9");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 5), "q10");

    // Reset with cnt=-3 and two queued addresses, then a fresh len=1 transfer.
    apply(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0, 5), "r0");
    apply(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0, 4), "r1");
    apply(mk(0, 1, 9, 2, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3), "r2");
    apply(mk(0, 1, 10, 3, 0, 0, 1, 1, 1, 9, 2, 0, 0, 0, 3), "r3");
    apply(mk(1, 0, 0, 1, 0, 0,  1, 1, 1, 9, 2, 0, 0, 0, 3), "r4_rst");
    apply(mk(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0), "r5_after_rst");
    apply(mk(0, 1, 6, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0), "r6");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 1, 6, 1, 0, 0, 0, 0), "r7");
    apply(mk(0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 1), "r8");
    apply(mk(0, 0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0), "r9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
